// File: rtl/lcd_reset_seq.sv
// rtl/lcd_reset_seq.sv - panel RESX sequencer: pre-hold high, low pulse, post-reset settle.
// Optional macro LCD_RESET_SEQ_AUTOSTART_EN: run one sequence automatically after rst.
module lcd_reset_seq #(
  parameter int PRE_CYC  = 40,
  parameter int LOW_CYC  = 400,
  parameter int POST_CYC = 4_800_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_phase,
  output logic       o_reset
);

  localparam int MAX_PL  = (PRE_CYC > LOW_CYC) ? PRE_CYC : LOW_CYC;
  localparam int MAX_CYC = (MAX_PL > POST_CYC) ? MAX_PL : POST_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  if (LOW_CYC < 1) begin : g_bad_low_cyc
    $error("lcd_reset_seq: LOW_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_LOW  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reset_q, reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       phase_q, phase_d;
  logic             start_eff;

`ifdef LCD_RESET_SEQ_AUTOSTART_EN
  // Armed only for the first clock after rst; an abort in that cycle simply wins.
  logic armed_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed_q <= 1'b1;
    else     armed_q <= 1'b0;
  end
  assign start_eff = i_start | armed_q;
`else
  assign start_eff = i_start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      reset_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_eff) begin
            if (PRE_CYC != 0) begin
              state_d = S_PRE;
              cnt_d   = CNT_W'(PRE_CYC - 1);
            end else begin
              state_d = S_LOW;
              cnt_d   = CNT_W'(LOW_CYC - 1);
            end
          end
        end
        S_PRE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_LOW;
            cnt_d   = CNT_W'(LOW_CYC - 1);
          end
        end
        S_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (POST_CYC != 0) begin
            state_d = S_POST;
            cnt_d   = CNT_W'(POST_CYC - 1);
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_POST: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every output flop toggles with the state.
  always_comb begin
    reset_d = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    phase_d = 2'd0;
    case (state_d)
      S_PRE: begin
        busy_d  = 1'b1;
        phase_d = 2'd1;
      end
      S_LOW: begin
        busy_d  = 1'b1;
        phase_d = 2'd2;
        reset_d = 1'b0;
      end
      S_POST: begin
        busy_d  = 1'b1;
        phase_d = 2'd3;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign o_reset = reset_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_lcd_reset_seq.sv
// tb/tb_lcd_reset_seq.sv - checks two lcd_reset_seq configurations against a sequence-position model.
module tb_lcd_reset_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic       busy_w  [2];
  logic       done_w  [2];
  logic [1:0] phase_w [2];
  logic       reset_w [2];

  int total = 0;
  int bad   = 0;

  localparam int P [2] = '{2, 0};
  localparam int L [2] = '{3, 3};
  localparam int Q [2] = '{4, 0};

  always #5 clk = ~clk;

  lcd_reset_seq #(.PRE_CYC(2), .LOW_CYC(3), .POST_CYC(4)) u_a (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_phase(phase_w[0]), .o_reset(reset_w[0])
  );

  lcd_reset_seq #(.PRE_CYC(0), .LOW_CYC(3), .POST_CYC(0)) u_b (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_phase(phase_w[1]), .o_reset(reset_w[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position k within the sequence, 1..T are busy cycles, T+1 is the done cycle.
  bit active [2] = '{0, 0};
  int k      [2] = '{0, 0};
  bit armed      = 1'b1;

  always @(posedge clk or posedge rst) begin
    bit go;
    if (rst) begin
      active = '{0, 0};
      armed  = 1'b1;
    end else begin
`ifdef LCD_RESET_SEQ_AUTOSTART_EN
      go = start | armed;
`else
      go = start;
`endif
      for (int m = 0; m < 2; m++) begin
        if (abort) active[m] = 0;
        else if (active[m]) begin
          if (k[m] == P[m] + L[m] + Q[m] + 1) active[m] = 0;
          else k[m]++;
        end else if (go) begin
          active[m] = 1;
          k[m] = 1;
        end
      end
      armed = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int t, eb, ed, ep, er;
      t  = P[m] + L[m] + Q[m];
      eb = (active[m] && k[m] <= t) ? 1 : 0;
      ed = (active[m] && k[m] == t + 1) ? 1 : 0;
      ep = !active[m] ? 0 : (k[m] <= P[m]) ? 1 : (k[m] <= P[m] + L[m]) ? 2 : (k[m] <= t) ? 3 : 0;
      er = (active[m] && k[m] > P[m] && k[m] <= P[m] + L[m]) ? 0 : 1;
      chk($sformatf("busy[%0d]", m),  int'(busy_w[m]),  eb);
      chk($sformatf("done[%0d]", m),  int'(done_w[m]),  ed);
      chk($sformatf("phase[%0d]", m), int'(phase_w[m]), ep);
      chk($sformatf("reset[%0d]", m), int'(reset_w[m]), er);
    end
  end

  int bz [2], lw [2], dn [2], ph13 [2], done_at [2];

  task automatic clear_counts();
    for (int m = 0; m < 2; m++) begin
      bz[m] = 0; lw[m] = 0; dn[m] = 0; ph13[m] = 0; done_at[m] = -1;
    end
  endtask

  task automatic tally(input int i);
    for (int m = 0; m < 2; m++) begin
      if (busy_w[m]) bz[m]++;
      if (!reset_w[m]) lw[m]++;
      if (done_w[m]) begin dn[m]++; done_at[m] = i; end
      if (phase_w[m] == 2'd1 || phase_w[m] == 2'd3) ph13[m]++;
    end
  endtask

  // Raise start for one cycle, then watch n cycles; optionally pulse abort after window abort_at.
  task automatic pulse_and_watch(input int n, input int abort_at);
    clear_counts();
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = 1'b0;
      tally(i);
      abort = (i == abort_at);
    end
    abort = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_reset_a", int'(reset_w[0]), 1);
    chk("rst_busy_a",  int'(busy_w[0]),  0);
    chk("rst_phase_a", int'(phase_w[0]), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Full sequence on both configurations
    pulse_and_watch(14, 0);
    chk("seq_busy_a",    bz[0], 9);
    chk("seq_low_a",     lw[0], 3);
    chk("seq_done_a",    dn[0], 1);
    chk("seq_done_at_a", done_at[0], 10);
    chk("seq_busy_b",    bz[1], 3);
    chk("seq_low_b",     lw[1], 3);
    chk("seq_done_at_b", done_at[1], 4);
    chk("seq_ph13_b",    ph13[1], 0);

    // Abort while u_a is in LOW
    pulse_and_watch(14, 4);
    chk("abort_busy_a", bz[0], 4);
    chk("abort_low_a",  lw[0], 2);
    chk("abort_done_a", dn[0], 0);
    chk("abort_done_b", dn[1], 1);
    pulse_and_watch(14, 0);
    chk("after_abort_busy_a", bz[0], 9);
    chk("after_abort_done_a", dn[0], 1);

    // start held high: back-to-back sequences
    clear_counts();
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tally(i);
    end
    start = 1'b0;
    chk("held_done_a", dn[0], 2);
    chk("held_done_b", dn[1], 6);
    repeat (15) @(negedge clk);

    // Asynchronous reset during POST
    pulse_and_watch(7, 0);
    chk("pre_rst_phase_a", int'(phase_w[0]), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_a", int'(reset_w[0]), 1);
    chk("async_busy_a",  int'(busy_w[0]),  0);
    chk("async_phase_a", int'(phase_w[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_counts();
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      tally(i);
    end
`ifdef LCD_RESET_SEQ_AUTOSTART_EN
    chk("autostart_busy_a", bz[0], 9);
    chk("autostart_done_a", dn[0], 1);
`else
    chk("post_rst_idle_a", bz[0], 0);
    chk("post_rst_idle_b", bz[1], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
